dcache_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the 32-byte, byte-addressed, word-wide data cache.
- Shares the single cache port between requester 0 (CPU load/store unit) and requester 1 (debug/DMA loader) with round-robin priority.
- Adds byte-enable writes via read-modify-write, which the cache does not support natively.
- Sits between the requesters and the cache's address, data_in, write_enable and data_out pins.

---
 rtl/dcache_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_dcache_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_arbiter.sv
// Round-robin two-port arbiter in front of the word-wide data cache, adding byte-enable writes via read-modify-write.
// Optional alignment check enabled by defining DCACHE_ARB_ALIGN_CHECK_EN.
module dcache_arbiter #(
    parameter int WIDTH     = 32,
    parameter int WIDTH_ADD = 5,
    parameter int BYTE      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0,
    input  logic                    req1,
    input  logic                    we0,
    input  logic                    we1,
    input  logic [WIDTH_ADD-1:0]    addr0,
    input  logic [WIDTH_ADD-1:0]    addr1,
    input  logic [WIDTH-1:0]        wdata0,
    input  logic [WIDTH-1:0]        wdata1,
    input  logic [WIDTH/BYTE-1:0]   be0,
    input  logic [WIDTH/BYTE-1:0]   be1,
    output logic                    gnt0,
    output logic                    gnt1,
    output logic                    done0,
    output logic                    done1,
    output logic                    err,
    output logic [WIDTH-1:0]        rdata,
    output logic [WIDTH_ADD-1:0]    cache_address,
    output logic [WIDTH-1:0]        cache_data_in,
    output logic                    cache_write_enable,
    input  logic [WIDTH-1:0]        cache_data_out
);
    localparam int LANES = WIDTH / BYTE;

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_prio;
    logic                   r_sel;
    logic                   r_we;
    logic                   r_misalign;
    logic [WIDTH-1:0]       r_wdata;
    logic [LANES-1:0]       r_be;
    logic                   r_gnt0;
    logic                   r_gnt1;
    logic                   r_done0;
    logic                   r_done1;
    logic                   r_err;
    logic [WIDTH-1:0]       r_rdata;
    logic [WIDTH_ADD-1:0]   r_cache_address;
    logic [WIDTH-1:0]       r_cache_data_in;
    logic                   r_cache_we;

    logic                   w_grant;
    logic                   w_pick;
    logic                   w_we;
    logic [WIDTH_ADD-1:0]   w_addr;
    logic [WIDTH-1:0]       w_wdata;
    logic [LANES-1:0]       w_be;
    logic                   w_misalign;
    logic                   w_partial;
    logic [WIDTH-1:0]       w_merge;

    assign w_grant = req0 || req1;
    assign w_pick  = (req0 && req1) ? r_prio : !req0;
    assign w_we    = w_pick ? we1    : we0;
    assign w_addr  = w_pick ? addr1  : addr0;
    assign w_wdata = w_pick ? wdata1 : wdata0;
    assign w_be    = w_pick ? be1    : be0;

`ifdef DCACHE_ARB_ALIGN_CHECK_EN
    assign w_misalign = |w_addr[1:0];
`else
    assign w_misalign = 1'b0;
`endif

    assign w_partial = r_we && !(&r_be) && (|r_be);

    always_comb begin
        w_merge = cache_data_out;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (r_be[i]) begin
                w_merge[i*BYTE +: BYTE] = r_wdata[i*BYTE +: BYTE];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_next_state = w_misalign ? DONE : ACCESS;
            ACCESS:  w_next_state = w_partial ? WRITE : DONE;
            WRITE:   w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // The merge is folded straight into the data_in register, so the
    // read-back word never needs its own storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio          <= 1'b0;
            r_sel           <= 1'b0;
            r_we            <= 1'b0;
            r_misalign      <= 1'b0;
            r_wdata         <= '0;
            r_be            <= '0;
            r_gnt0          <= 1'b0;
            r_gnt1          <= 1'b0;
            r_done0         <= 1'b0;
            r_done1         <= 1'b0;
            r_err           <= 1'b0;
            r_rdata         <= '0;
            r_cache_address <= '0;
            r_cache_data_in <= '0;
            r_cache_we      <= 1'b0;
        end else begin
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_err      <= 1'b0;
            r_cache_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_sel      <= w_pick;
                        r_we       <= w_we;
                        r_wdata    <= w_wdata;
                        r_be       <= w_be;
                        r_misalign <= w_misalign;
                        r_gnt0     <= !w_pick;
                        r_gnt1     <= w_pick;
                        if (!w_misalign) begin
                            r_cache_address <= w_addr;
                            if (w_we && (&w_be)) begin
                                r_cache_data_in <= w_wdata;
                                r_cache_we      <= 1'b1;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (!r_we) begin
                        r_rdata <= cache_data_out;
                    end else if (w_partial) begin
                        r_cache_data_in <= w_merge;
                        r_cache_we      <= 1'b1;
                    end
                end
                DONE: begin
                    r_done0 <= !r_sel;
                    r_done1 <= r_sel;
                    r_err   <= r_misalign;
                    r_prio  <= !r_sel;
                    if (r_misalign) begin
                        r_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt0               = r_gnt0;
    assign gnt1               = r_gnt1;
    assign done0              = r_done0;
    assign done1              = r_done1;
    assign err                = r_err;
    assign rdata              = r_rdata;
    assign cache_address      = r_cache_address;
    assign cache_data_in      = r_cache_data_in;
    assign cache_write_enable = r_cache_we;

endmodule

// File: tb/tb_dcache_arbiter.sv
// Directed bench for dcache_arbiter with a byte-addressed 32-byte cache model.
module tb_dcache_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_init = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [4:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic [3:0]  be0 = '0, be1 = '0;
    logic        gnt0, gnt1, done0, done1, err, cwe;
    logic [31:0] rdata, cdin, cdout;
    logic [4:0]  caddr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dcache_arbiter #(.WIDTH(32), .WIDTH_ADD(5), .BYTE(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .be0(be0), .be1(be1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
        .rdata(rdata), .cache_address(caddr), .cache_data_in(cdin),
        .cache_write_enable(cwe), .cache_data_out(cdout)
    );

    // Cache model: little-endian word over four consecutive bytes, modulo-32 wrap
    logic [7:0] mem [32];
    logic [4:0] a1, a2, a3;
    always_comb begin
        a1 = caddr + 5'd1;
        a2 = caddr + 5'd2;
        a3 = caddr + 5'd3;
        cdout = {mem[a3], mem[a2], mem[a1], mem[caddr]};
    end
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'(i);
        end else if (cwe) begin
            mem[caddr] <= cdin[7:0];
            mem[a1]    <= cdin[15:8];
            mem[a2]    <= cdin[23:16];
            mem[a3]    <= cdin[31:24];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " gnt/done/err"}, {29'd0, gnt0 | gnt1, done0 | done1, err}, 32'd0);
        check({tag, " rdata"}, rdata, 32'd0);
        check({tag, " cwe"}, {31'd0, cwe}, 32'd0);
        check({tag, " caddr"}, {27'd0, caddr}, 32'd0);
        check({tag, " cdin"}, cdin, 32'd0);
    endtask

    // Issues one request, drops req right after gnt, and watches up to 12 cycles
    task automatic run_op(input logic port, input logic we, input logic [4:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          output int gnt_cyc, output int done_cyc, output int nwr,
                          output logic ports_ok, output logic [31:0] rd, output logic e);
        @(negedge clk);
        if (port) begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; be1 = be;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; be0 = be;
        end
        gnt_cyc = -1; done_cyc = -1; nwr = 0; ports_ok = 1'b1; rd = 'x; e = 1'bx;
        for (int c = 1; c <= 12 && done_cyc < 0; c++) begin
            @(posedge clk); #1;
            if (gnt0 | gnt1) begin
                if (gnt_cyc < 0) gnt_cyc = c;
                if (port ? (gnt0 || !gnt1) : (gnt1 || !gnt0)) ports_ok = 1'b0;
                req0 = 1'b0; req1 = 1'b0;
            end
            if (cwe) nwr++;
            if (done0 | done1) begin
                done_cyc = c;
                if (port ? (done0 || !done1) : (done1 || !done0)) ports_ok = 1'b0;
                rd = rdata;
                e = err;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        port;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        int          exp_lat;
        int          exp_wr;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic apply(input vec_t v);
        int gc, dc, nw;
        logic ok, e;
        logic [31:0] rd;
        run_op(v.port, v.we, v.addr, v.wdata, v.be, gc, dc, nw, ok, rd, e);
        check({v.name, " gnt cycle"}, gc, 1);
        check({v.name, " latency"}, dc - gc, v.exp_lat);
        check({v.name, " write pulses"}, nw, v.exp_wr);
        check({v.name, " port"}, {31'd0, ok}, 32'd1);
        check({v.name, " err"}, {31'd0, e}, {31'd0, v.exp_err});
        if (!v.we || v.exp_err) check({v.name, " rdata"}, rd, v.exp_rd);
    endtask

    initial begin
        int gseq[4];
        int ng, nd;
        logic [31:0] rd_first;
        logic [4:0] caddr_before;
        logic got;

        vecs.push_back('{"wr4_full",   1'b0, 1'b1, 5'd4,  32'hDEADBEEF, 4'hF, 32'h0,        2, 1, 1'b0});
        vecs.push_back('{"rd4",        1'b0, 1'b0, 5'd4,  32'h0,        4'h0, 32'hDEADBEEF, 2, 0, 1'b0});
        vecs.push_back('{"wr8_full",   1'b0, 1'b1, 5'd8,  32'h11223344, 4'hF, 32'h0,        2, 1, 1'b0});
        vecs.push_back('{"wr8_part",   1'b0, 1'b1, 5'd8,  32'hAABBCCDD, 4'h5, 32'h0,        3, 1, 1'b0});
        vecs.push_back('{"rd8",        1'b0, 1'b0, 5'd8,  32'h0,        4'h0, 32'h11BB33DD, 2, 0, 1'b0});
        vecs.push_back('{"wr12_empty", 1'b0, 1'b1, 5'd12, 32'hFFFFFFFF, 4'h0, 32'h0,        2, 0, 1'b0});
        vecs.push_back('{"rd12",       1'b0, 1'b0, 5'd12, 32'h0,        4'h0, 32'h0F0E0D0C, 2, 0, 1'b0});
        vecs.push_back('{"wr16_lane3", 1'b1, 1'b1, 5'd16, 32'hCAFEF00D, 4'h8, 32'h0,        3, 1, 1'b0});
        vecs.push_back('{"rd16_p1",    1'b1, 1'b0, 5'd16, 32'h0,        4'h0, 32'hCA121110, 2, 0, 1'b0});
        vecs.push_back('{"rd0",        1'b0, 1'b0, 5'd0,  32'h0,        4'h0, 32'h03020100, 2, 0, 1'b0});
        vecs.push_back('{"rd28_p1",    1'b1, 1'b0, 5'd28, 32'h0,        4'h0, 32'h1F1E1D1C, 2, 0, 1'b0});
`ifdef DCACHE_ARB_ALIGN_CHECK_EN
        vecs.push_back('{"rd5_misal",  1'b0, 1'b0, 5'd5,  32'h0,        4'h0, 32'h0,        1, 0, 1'b1});
        vecs.push_back('{"wr6_misal",  1'b1, 1'b1, 5'd6,  32'h12345678, 4'hF, 32'h0,        1, 0, 1'b1});
        vecs.push_back('{"rd8_after",  1'b0, 1'b0, 5'd8,  32'h0,        4'h0, 32'h11BB33DD, 2, 0, 1'b0});
`else
        vecs.push_back('{"rd5_unal",   1'b0, 1'b0, 5'd5,  32'h0,        4'h0, 32'hDDDEADBE, 2, 0, 1'b0});
        vecs.push_back('{"rd30_wrap",  1'b1, 1'b0, 5'd30, 32'h0,        4'h0, 32'h01001F1E, 2, 0, 1'b0});
        vecs.push_back('{"wr31_wrap",  1'b0, 1'b1, 5'd31, 32'h55667788, 4'hF, 32'h0,        2, 1, 1'b0});
        vecs.push_back('{"rd0_wrap",   1'b1, 1'b0, 5'd0,  32'h0,        4'h0, 32'h03556677, 2, 0, 1'b0});
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        mem_init = 1'b0;

        caddr_before = '0;
        foreach (vecs[i]) begin
            if (vecs[i].exp_err) caddr_before = caddr;
            apply(vecs[i]);
            if (vecs[i].exp_err) check({vecs[i].name, " caddr untouched"}, {27'd0, caddr}, {27'd0, caddr_before});
        end

        // Reset in the middle of the WRITE phase of a partial write to word 20
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'd20; wdata0 = 32'h0; be0 = 4'b0011;
        @(posedge clk); #1;
        check("rmw gnt0", {31'd0, gnt0}, 32'd1);
        req0 = 1'b0;
        @(posedge clk); #1;
        check("rmw write enable", {31'd0, cwe}, 32'd1);
        check("rmw merged data", cdin, 32'h17160000);
        rst = 1'b1;
        #1;
        check("rmw async drop", {31'd0, cwe}, 32'd0);
        @(negedge clk);
        check_reset_values("midreset");
        rst = 1'b0;
        nd = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done0 | done1) nd++;
        end
        check("no done after reset", nd, 0);

        // Both requesters held with reads: grants must alternate starting at 0
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd20;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'd0;
        ng = 0; got = 1'b0; rd_first = '0;
        for (int c = 0; c < 30 && ng < 4; c++) begin
            @(posedge clk); #1;
            if (gnt0 && gnt1) check("dual grant", 32'd1, 32'd0);
            if (gnt0 || gnt1) begin
                gseq[ng] = gnt1 ? 1 : 0;
                ng++;
            end
            if (done0 && !got) begin
                got = 1'b1;
                rd_first = rdata;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("rr grant count", ng, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < ng) check($sformatf("rr grant %0d", i), gseq[i], i % 2);
        end
        check("word20 unchanged", rd_first, 32'h17161514);
        repeat (4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
